out_stream_tx: RTL and testbench

OUT_STREAM_TX -- requirements
Module: out_stream_tx

---
 rtl/out_stream_tx.sv | 80 ++++++++
 tb/tb_out_stream_tx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/out_stream_tx.sv
// Ping-pong M x T output buffer: a committed bank streams one word per handshake, first word the cycle after commit.
// Stalls hold output_data; wr_ready drops while both banks are full. Define OUT_STREAM_RELU_EN to clamp negative words to 0.
module out_stream_tx #(
  parameter int T  = 16,
  parameter int M  = 16,
  parameter int AW = $clog2(M)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic signed [T-1:0] wr_data,
  input  logic                wr_commit,
  output logic                wr_ready,
  output logic                output_valid,
  input  logic                output_ready,
  output logic signed [T-1:0] output_data
);

  logic signed [T-1:0] mem [2][M];
  logic [1:0]          full;
  logic                fill_sel;
  logic                send_sel;
  logic [AW-1:0]       send_cnt;
  logic signed [T-1:0] word;
  logic                do_wr;
  logic                do_commit;
  logic                xfer;
  logic                last;

  assign wr_ready     = ~full[fill_sel];
  assign output_valid = full[send_sel];

  // Out-of-range addresses are dropped rather than aliased onto a real word.
  assign do_wr     = wr_en & wr_ready & (int'(wr_addr) < M);
  assign do_commit = wr_commit & wr_ready;
  assign xfer      = output_valid & output_ready;
  assign last      = (send_cnt == AW'(M - 1));

  // Bank storage carries no reset; a commit-cycle write lands in the bank being committed.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[fill_sel][wr_addr] <= wr_data;
    end
  end

  // A commit only targets a free bank and a transfer only a full one, so the two
  // updates to full[] below never hit the same bit in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      full     <= 2'b00;
      fill_sel <= 1'b0;
      send_sel <= 1'b0;
      send_cnt <= '0;
    end else begin
      if (do_commit) begin
        full[fill_sel] <= 1'b1;
        fill_sel       <= ~fill_sel;
      end
      if (xfer) begin
        if (last) begin
          send_cnt       <= '0;
          full[send_sel] <= 1'b0;
          send_sel       <= ~send_sel;
        end else begin
          send_cnt <= send_cnt + AW'(1);
        end
      end
    end
  end

  assign word = mem[send_sel][send_cnt];

`ifdef OUT_STREAM_RELU_EN
  assign output_data = word[T-1] ? '0 : word;
`else
  assign output_data = word;
`endif

endmodule

// File: tb/tb_out_stream_tx.sv
// Scoreboard bench for out_stream_tx: directed vectors push expected words, a negedge monitor pops and compares.
module tb_out_stream_tx;
  localparam int T  = 16;
  localparam int M  = 16;
  localparam int AW = $clog2(M);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [T-1:0]  wr_data = '0;
  logic          wr_commit = 1'b0;
  logic          wr_ready;
  logic          output_valid;
  logic          output_ready = 1'b0;
  logic [T-1:0]  output_data;

  int           checks = 0;
  int           errors = 0;
  logic [T-1:0] exp_q[$];
  logic [T-1:0] vec[M];
  bit           stalled = 1'b0;
  logic [T-1:0] held = '0;

  out_stream_tx #(.T(T), .M(M), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_commit    (wr_commit),
    .wr_ready     (wr_ready),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [T-1:0] expect_word(input logic [T-1:0] w);
`ifdef OUT_STREAM_RELU_EN
    return w[T-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  // Writes vec in descending address order; word 0 shares its cycle with the commit.
  task automatic fill_commit(input bit push);
    for (int a = M - 1; a >= 0; a--) begin
      wr_en     = 1'b1;
      wr_addr   = AW'(a);
      wr_data   = vec[a];
      wr_commit = (a == 0);
      @(posedge clk); #1;
    end
    wr_en     = 1'b0;
    wr_commit = 1'b0;
    if (push) begin
      for (int i = 0; i < M; i++) exp_q.push_back(expect_word(vec[i]));
    end
  endtask

  task automatic drain(input int bound, input bit rnd);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      if (rnd) output_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    output_ready = 1'b1;
    check("drain_empty", 32'(exp_q.size()), 0);
  endtask

  // Monitor: compares every transfer against the scoreboard and checks stall stability.
  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", 32'(output_valid), 1);
        check("stall_data", 32'(output_data), 32'(held));
      end
      if (output_valid && output_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer: data %0h with empty scoreboard at %0t", output_data, $time);
        end else begin
          check("data", 32'(output_data), 32'(exp_q.pop_front()));
        end
      end
      stalled = output_valid && !output_ready;
      held    = output_data;
    end
  end

  initial begin
    int cnt;
    int n;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(output_valid), 0);
    check("rst_wr_ready", 32'(wr_ready), 1);
    reset = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("idle_valid", 32'(output_valid), 0);
      check("idle_wr_ready", 32'(wr_ready), 1);
    end

    // Single vector, ready held high: back-to-back transfers
    output_ready = 1'b1;
    for (int i = 0; i < M; i++) vec[i] = T'(i * 3);
    fill_commit(1'b1);
    check("valid_after_commit", 32'(output_valid), 1);
    for (int i = 0; i < M; i++) begin
      @(negedge clk);
      check("b2b_valid", 32'(output_valid), 1);
    end
    @(posedge clk); #1;
    check("valid_drop_after_vec", 32'(output_valid), 0);
    check("t1_queue_empty", 32'(exp_q.size()), 0);

    // Same vector with random backpressure
    fill_commit(1'b1);
    drain(400, 1'b1);

    // A and B back to back, C attempted while both banks are full
    output_ready = 1'b0;
    for (int i = 0; i < M; i++) vec[i] = T'(16'h0100 + i);
    fill_commit(1'b1);
    for (int i = 0; i < M; i++) vec[i] = T'(16'h0200 + i);
    fill_commit(1'b1);
    check("both_full_wr_ready", 32'(wr_ready), 0);
    for (int i = 0; i < M; i++) vec[i] = T'(16'h7777);
    fill_commit(1'b0);
    check("c_ignored_wr_ready", 32'(wr_ready), 0);
    output_ready = 1'b1;
    cnt = 0;
    n   = 0;
    while (cnt < M && n < 100) begin
      @(negedge clk);
      n++;
      check("a_wr_ready_low", 32'(wr_ready), 0);
      if (output_valid && output_ready) cnt++;
    end
    check("a_count", 32'(cnt), M);
    check("a_no_bubble", 32'(n), M);
    @(posedge clk); #1;
    check("wr_ready_after_a", 32'(wr_ready), 1);
    check("b_follows_a", 32'(output_valid), 1);
    drain(100, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("c_not_sent", 32'(output_valid), 0);

    // Sign handling: negative word clamped only with RELU enabled
    for (int i = 0; i < M; i++) vec[i] = T'(i);
    vec[0] = 16'h8001;
    vec[1] = 16'h0005;
    vec[2] = 16'hFFFF;
    fill_commit(1'b1);
    drain(100, 1'b0);

    // Reset mid-vector after word 7
    for (int i = 0; i < M; i++) vec[i] = T'(16'h0300 + i);
    fill_commit(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(expect_word(vec[i]));
    cnt = 0;
    n   = 0;
    while (cnt < 8 && n < 100) begin
      @(negedge clk);
      n++;
      if (output_valid && output_ready) cnt++;
    end
    check("pre_reset_count", 32'(cnt), 8);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset_valid_low", 32'(output_valid), 0);
    check("reset_wr_ready", 32'(wr_ready), 1);
    reset = 1'b0;
    check("reset_queue_empty", 32'(exp_q.size()), 0);
    repeat (2) @(posedge clk);
    #1;
    check("post_reset_idle", 32'(output_valid), 0);
    for (int i = 0; i < M; i++) vec[i] = T'(16'h0400 + i);
    fill_commit(1'b1);
    check("post_reset_valid", 32'(output_valid), 1);
    check("post_reset_word0", 32'(output_data), 32'(expect_word(vec[0])));
    drain(100, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
